// File: rtl/frame_serializer.sv
// frame_serializer: accepts parallel payload words over a valid/ready
// handshake and shifts them out one bit per clock, framing the stream for a
// serial CRC-5 stage. Each frame begins with a crc_clr strobe. frame_done
// pulses once the CRC stage has absorbed the final bit. The sticky flags
// underrun and overlength report bubbles and frame truncation.
//
// Build option: define SER_LSB_FIRST_EN to emit each word bit 0 first.
// The default build emits bit WORD_W-1 first.
module frame_serializer #(
  parameter int WORD_W    = 8,
  parameter int MAX_WORDS = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic              sd,
  output logic              sd_valid,
  output logic              crc_clr,
  output logic              frame_done,
  output logic              underrun,
  output logic              overlength
);

  localparam int CNT_W = $clog2(MAX_WORDS + 1);
  localparam int BIT_W = $clog2(WORD_W);

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    SHIFT,
    WAIT,
    DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WORD_W-1:0] shreg;
  logic [WORD_W-1:0] shreg_shifted;
  logic [BIT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  word_cnt;
  logic [CNT_W-1:0]  word_cnt_nxt;
  logic              last_q;
  logic              run;        // low for one cycle after reset so in_ready stays 0
  logic              accept;
  logic              cur_bit;
  logic              last_bit;
  logic              force_last;

`ifdef SER_LSB_FIRST_EN
  assign cur_bit       = shreg[0];
  assign shreg_shifted = {1'b0, shreg[WORD_W-1:1]};
`else
  assign cur_bit       = shreg[WORD_W-1];
  assign shreg_shifted = {shreg[WORD_W-2:0], 1'b0};
`endif

  assign accept       = in_valid & in_ready;
  assign last_bit     = (bit_cnt == '0);
  // A word taken in IDLE always starts a new frame; any other accept extends it.
  assign word_cnt_nxt = (state == IDLE) ? CNT_W'(1) : word_cnt + CNT_W'(1);
  // The word that reaches MAX_WORDS ends the frame even without in_last.
  assign force_last   = (word_cnt_nxt == CNT_W'(MAX_WORDS)) && !in_last;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and Moore/Mealy outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_nxt  = state;
    in_ready   = 1'b0;
    sd         = 1'b0;
    sd_valid   = 1'b0;
    crc_clr    = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        in_ready = run;
        if (accept) state_nxt = CLR;
      end
      CLR: begin
        crc_clr   = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        sd       = cur_bit;
        sd_valid = 1'b1;
        if (last_bit) begin
          if (last_q) begin
            state_nxt = DONE;
          end else begin
            in_ready = 1'b1;
            if (!in_valid) state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SHIFT;
      end
      DONE: begin
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift register, counters, latched last and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      last_q     <= 1'b0;
      run        <= 1'b0;
      underrun   <= 1'b0;
      overlength <= 1'b0;
    end else begin
      run <= 1'b1;
      if (accept) begin
        shreg    <= in_data;
        bit_cnt  <= BIT_W'(WORD_W - 1);
        word_cnt <= word_cnt_nxt;
        last_q   <= in_last | force_last;
        if (force_last) overlength <= 1'b1;
      end else if (state == SHIFT && !last_bit) begin
        shreg   <= shreg_shifted;
        bit_cnt <= bit_cnt - BIT_W'(1);
      end
      // Every WAIT cycle feeds a zero into the CRC stage.
      if (state == WAIT) underrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_frame_serializer.sv
// Self-checking bench for frame_serializer (WORD_W=8, MAX_WORDS=2).
// The reference model splits the offered word list into frames, builds the
// expected serial bit stream, and predicts bubble counts and sticky flags.
module tb_frame_serializer;

  localparam int W    = 8;
  localparam int MAXW = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic         in_ready, sd, sd_valid, crc_clr, frame_done, underrun, overlength;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] stim_w[$];
  bit           stim_l[$];
  int           stim_g[$];   // ready cycles to hold in_valid low before offering the word
  bit           cap_q[$];

  frame_serializer #(.WORD_W(W), .MAX_WORDS(MAXW)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .sd         (sd),
    .sd_valid   (sd_valid),
    .crc_clr    (crc_clr),
    .frame_done (frame_done),
    .underrun   (underrun),
    .overlength (overlength)
  );

  always #5 clk = ~clk;

  function automatic bit bit_at(logic [W-1:0] w, int i);
`ifdef SER_LSB_FIRST_EN
    return w[i];
`else
    return w[W-1-i];
`endif
  endfunction

  function automatic logic [15:0] cap_pack(int n);
    logic [15:0] r = '0;
    for (int i = 0; i < n; i++)
      if (i < cap_q.size()) r = {r[14:0], cap_q[i]};
      else                  r = {r[14:0], 1'b0};
    return r;
  endfunction

  task automatic do_reset;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Drives the stim_* word list and checks the resulting stream against the model.
  task automatic run_frames(input string name);
    int frames = 0, cnt = 0, exp_waits = 0;
    bit exp_ur = 0, exp_ovl = 0;
    bit exp_q[$];
    int n = stim_w.size();
    int idx = 0, wait_cnt = 0, cyc = 0, clr_cnt = 0, done_cnt = 0, waits_obs = 0, bad = 0;
    bit in_frame = 0, prev_valid = 0, pend_clr = 0, expect_bit = 0;
    int first_bad = -1;

    for (int i = 0; i < n; i++) begin
      if (cnt == 0) frames++;
      else if (stim_g[i] > 0) begin
        exp_ur = 1;
        exp_waits += stim_g[i];
      end
      cnt++;
      for (int b = 0; b < W; b++) exp_q.push_back(bit_at(stim_w[i], b));
      if (stim_l[i] || cnt == MAXW) begin
        if (!stim_l[i]) exp_ovl = 1;
        cnt = 0;
      end
    end

    cap_q.delete();
    do_reset();
    if (n > 0 && stim_g[0] == 0) begin
      in_valid = 1'b1; in_data = stim_w[0]; in_last = stim_l[0];
    end else begin
      in_valid = 1'b0; in_data = W'($urandom); in_last = 1'($urandom);
    end

    while ((idx < n || done_cnt < frames) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (crc_clr !== pend_clr) bad++;
      if (expect_bit && sd_valid !== 1'b1) bad++;
      expect_bit = crc_clr;
      if (frame_done === 1'b1 && !prev_valid) bad++;
      if (sd_valid !== 1'b1 && sd !== 1'b0) bad++;
      if (sd_valid === 1'b1 && !in_frame) bad++;
      if (crc_clr === 1'b1) begin
        clr_cnt++;
        if (in_frame) bad++;
        in_frame = 1;
      end else if (frame_done === 1'b1) begin
        done_cnt++;
        if (!in_frame) bad++;
        in_frame = 0;
      end else if (in_frame && sd_valid !== 1'b1) begin
        waits_obs++;
      end
      if (sd_valid === 1'b1) cap_q.push_back(sd);
      prev_valid = (sd_valid === 1'b1);
      pend_clr = 0;
      if (idx < n) begin
        if (in_valid && in_ready === 1'b1) begin
          pend_clr = !in_frame;
          idx++;
          wait_cnt = 0;
        end else if (!in_valid && in_ready === 1'b1) begin
          wait_cnt++;
        end
      end
      @(posedge clk);
      #1;
      if (idx < n && wait_cnt >= stim_g[idx]) begin
        in_valid = 1'b1; in_data = stim_w[idx]; in_last = stim_l[idx];
      end else begin
        in_valid = 1'b0; in_data = W'($urandom); in_last = 1'($urandom);
      end
    end

    checks++;
    if (cyc >= 2000) begin
      errors++;
      $display("FAIL %s timeout: frames_done=%0d words_sent=%0d required frames=%0d words=%0d",
               name, done_cnt, idx, frames, n);
    end

    @(negedge clk);
    checks++;
    if (cap_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL %s bit_count: got %0d required %0d", name, cap_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++)
        if (first_bad < 0 && cap_q[i] !== exp_q[i]) first_bad = i;
      checks++;
      if (first_bad >= 0) begin
        errors++;
        $display("FAIL %s stream: bit %0d got %0d required %0d", name, first_bad,
                 cap_q[first_bad], exp_q[first_bad]);
      end
    end
    checks++;
    if (clr_cnt !== frames) begin
      errors++;
      $display("FAIL %s crc_clr_count: got %0d required %0d", name, clr_cnt, frames);
    end
    checks++;
    if (done_cnt !== frames) begin
      errors++;
      $display("FAIL %s frame_done_count: got %0d required %0d", name, done_cnt, frames);
    end
    checks++;
    if (waits_obs !== exp_waits) begin
      errors++;
      $display("FAIL %s bubble_cycles: got %0d required %0d", name, waits_obs, exp_waits);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL %s framing_timing: got %0d violations required 0", name, bad);
    end
    checks++;
    if (underrun !== exp_ur) begin
      errors++;
      $display("FAIL %s underrun: got %b required %b", name, underrun, exp_ur);
    end
    checks++;
    if (overlength !== exp_ovl) begin
      errors++;
      $display("FAIL %s overlength: got %b required %b", name, overlength, exp_ovl);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    in_valid = 1'b1;
    in_data = 8'hFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({in_ready, sd, sd_valid, crc_clr, frame_done, underrun, overlength} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 0000000",
               {in_ready, sd, sd_valid, crc_clr, frame_done, underrun, overlength});
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_single;
    stim_w = '{8'hA5}; stim_l = '{1'b1}; stim_g = '{0};
    run_frames("single");
    checks++;
    if (cap_pack(8) !== 16'h00A5) begin
      errors++;
      $display("FAIL single_bits: got %h required a5", cap_pack(8));
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] exp16;
`ifdef SER_LSB_FIRST_EN
    exp16 = 16'b0000111111110000;
`else
    exp16 = 16'b1111000000001111;
`endif
    stim_w = '{8'hF0, 8'h0F}; stim_l = '{1'b0, 1'b1}; stim_g = '{0, 0};
    run_frames("back_to_back");
    checks++;
    if (cap_pack(16) !== exp16) begin
      errors++;
      $display("FAIL back_to_back_bits: got %b required %b", cap_pack(16), exp16);
    end
  endtask

  task automatic test_underrun;
    stim_w = '{8'h81, 8'h01}; stim_l = '{1'b0, 1'b1}; stim_g = '{0, 3};
    run_frames("underrun");
  endtask

  task automatic test_overlength;
    stim_w = '{W'($urandom), W'($urandom), W'($urandom), W'($urandom)};
    stim_l = '{1'b0, 1'b0, 1'b0, 1'b1};
    stim_g = '{0, 0, 0, 0};
    run_frames("overlength");
  endtask

  task automatic test_lsb_order;
    logic [7:0] exp8;
`ifdef SER_LSB_FIRST_EN
    exp8 = 8'b10000000;
`else
    exp8 = 8'b00000001;
`endif
    stim_w = '{8'h01}; stim_l = '{1'b1}; stim_g = '{1};
    run_frames("bit_order");
    checks++;
    if (cap_pack(8) !== {8'h00, exp8}) begin
      errors++;
      $display("FAIL bit_order_bits: got %b required %b", cap_pack(8), exp8);
    end
  endtask

  task automatic test_random;
    for (int it = 0; it < 8; it++) begin
      int n = $urandom_range(1, 6);
      stim_w.delete(); stim_l.delete(); stim_g.delete();
      for (int i = 0; i < n; i++) begin
        stim_w.push_back(W'($urandom));
        stim_l.push_back(i == n - 1 ? 1'b1 : ($urandom_range(0, 2) == 0));
        stim_g.push_back($urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0);
      end
      run_frames($sformatf("random%0d", it));
    end
  endtask

  task automatic test_mid_reset;
    int nbits = 0, guard = 0, dones = 0;
    stim_w = '{8'h81, 8'h01}; stim_l = '{1'b0, 1'b1}; stim_g = '{0, 2};
    run_frames("pre_reset_underrun");
    in_valid = 1'b1; in_data = 8'hFF; in_last = 1'b1;
    while (nbits < 4 && guard < 40) begin
      @(negedge clk);
      guard++;
      if (sd_valid === 1'b1) nbits++;
      if (nbits < 4) begin
        if (in_valid && in_ready === 1'b1) begin
          @(posedge clk);
          #1 in_valid = 1'b0;
        end
      end
    end
    checks++;
    if (nbits < 4) begin
      errors++;
      $display("FAIL mid_reset_start: got %0d bits required 4", nbits);
    end
    reset = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready, sd_valid, crc_clr, frame_done, underrun, overlength} !== 6'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %b required 000000",
               {in_ready, sd_valid, crc_clr, frame_done, underrun, overlength});
    end
    for (int i = 0; i < 12; i++) begin
      if (frame_done === 1'b1 || sd_valid === 1'b1) dones++;
      @(negedge clk);
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL mid_reset_discard: got %0d activity cycles required 0", dones);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_ready: got %b required 1", in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_underrun();
    test_overlength();
    test_lsb_order();
    test_random();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_serializer.md
# frame_serializer

- Upstream feeder for the serial CRC-5 stage: accepts parallel payload words over a valid/ready handshake and shifts them out one bit per clock.
- Frames the stream for the CRC stage:
  - pulses a clear strobe before the first bit of each frame;
  - flags the cycle in which the CRC register holds the final frame value.
- Tracks frame length and reports underrun and overlength errors.

## Interface
- WORD_W, 8, payload word width in bits (≥2).
- MAX_WORDS, 16, maximum words per frame (≥1); counter width is $clog2(MAX_WORDS+1).
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  WORD_W  payload word.
- in_valid  input  1  in_data/in_last valid.
- in_last  input  1  current word is the final word of the frame.
- in_ready  output  1  word accepted when in_valid & in_ready.
- sd  output  1  serial data bit, connects to the CRC stage data input.
- sd_valid  output  1  sd carries a payload bit this cycle.
- crc_clr  output  1  one-cycle clear strobe to the CRC stage.
- frame_done  output  1  one-cycle pulse: CRC stage holds the final frame CRC.
- underrun  output  1  sticky: a bubble occurred mid-frame.
- overlength  output  1  sticky: frame truncated at MAX_WORDS.

## Operation
- Reset values: all outputs 0, including in_ready, underrun and overlength. State is IDLE, word count 0, shift register 0.
- States: IDLE, CLR, SHIFT, WAIT, DONE.
- IDLE:
  - in_ready=1.
  - Handshake: load the shift register with in_data, latch in_last, set word count=1, go to CLR.
- CLR:
  - One cycle: crc_clr=1, sd=0, sd_valid=0.
  - Go to SHIFT.
- SHIFT:
  - sd = current bit, sd_valid=1, bit counter runs WORD_W-1 down to 0.
  - On the last bit of a word with latched last=1, go to DONE.
  - On the last bit of a word with latched last=0:
    - in_ready=1 in that cycle.
    - Handshake: reload the word, increment the count, stay in SHIFT with no bubble.
    - No handshake: go to WAIT.
- WAIT:
  - sd=0, sd_valid=0, in_ready=1.
  - Set underrun (the CRC stage has shifted a zero).
  - Handshake: go to SHIFT.
- Overlength:
  - If the word just reloaded makes the count equal MAX_WORDS and its in_last=0, force the latched last to 1 and set overlength.
  - The frame ends after that word.
  - Remaining upstream words start a new frame.
- DONE:
  - One cycle: frame_done=1, sd=0, sd_valid=0, in_ready=0.
  - Go to IDLE.
- Sticky flags clear only on reset.
- in_data and in_last are ignored when no handshake occurs.

## Timing
- Word handshake in cycle N (from IDLE):
  - crc_clr=1 at N+1.
  - Bits at N+2 through N+1+WORD_W.
- Back-to-back words: the last bit of word k and the handshake for word k+1 share a cycle; word k+1 bit 0 follows in the next cycle.
- frame_done: exactly one cycle after the final payload bit, when the CRC register reflects all payload bits.
- Minimum frame spacing: 2 cycles (DONE, then IDLE accept).
- Reset asserted mid-frame: next cycle all outputs are at reset values and the partial frame is discarded; no frame_done is issued.
- in_valid high in DONE: no acceptance; the word is taken in the following IDLE cycle.

## Configuration
- SER_LSB_FIRST_EN:
  - Defined: each word is emitted bit 0 first, bit WORD_W-1 last.
  - Undefined (default): MSB-first, bit WORD_W-1 first.
- All other behaviour and timing are identical in both builds.

## Test plan
- Single word 8'hA5, in_last=1, MSB-first build:
  - crc_clr at N+1.
  - sd = 1,0,1,0,0,1,0,1 at N+2..N+9 with sd_valid=1.
  - frame_done at N+10.
  - No flags set.
- Two back-to-back words 8'hF0 then 8'h0F (last):
  - 16 contiguous sd_valid cycles: 1111000000001111.
  - Single crc_clr, frame_done 1 cycle after bit 16.
- Underrun: word 8'h81, then in_valid held low 3 cycles, then 8'h01 last:
  - 3 WAIT cycles with sd_valid=0.
  - underrun=1 and stays 1 after frame_done.
- MAX_WORDS=2, three words with no in_last:
  - Frame ends after word 2, overlength=1.
  - Word 3 starts a new frame with its own crc_clr.
- Reset pulsed at the 4th bit of 8'hFF:
  - Next cycle: sd_valid=0, in_ready=0, flags 0, no frame_done.
  - After reset release, in_ready=1.
- SER_LSB_FIRST_EN build, word 8'h01 last: sd = 1,0,0,0,0,0,0,0.
